// File: rtl/instruction_fetch.sv
// Instruction fetch: a single outstanding memory request feeding a 2-entry output FIFO.
// Redirects flush the queue and the in-flight response and restart fetch at the new target.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic        inflight_valid;
    logic [1:0]  occupancy;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic [31:0] tail_pc;
    logic [31:0] tail_instr;
    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  committed;

    // Entries already queued or in flight, minus the one leaving this cycle,
    // must leave room so every in-flight response has a FIFO slot to land in.
    assign pop       = out_valid && out_ready;
    assign push      = inflight_valid;
    assign committed = {1'b0, occupancy} + {2'b00, inflight_valid} - {2'b00, pop};
    assign issue     = !reset && !redirect_valid && (committed < 3'd2);

    assign imem_addr = fetch_pc;
    assign imem_req  = issue;
    assign out_valid = (occupancy != 2'd0);
    assign out_pc    = head_pc;
    assign out_instr = head_instr;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            inflight_pc    <= 32'h0;
            inflight_valid <= 1'b0;
            occupancy      <= 2'd0;
            head_pc        <= 32'h0;
            head_instr     <= 32'h0;
            tail_pc        <= 32'h0;
            tail_instr     <= 32'h0;
        end else if (redirect_valid) begin
            fetch_pc       <= redirect_pc & ~32'h3;
            inflight_valid <= 1'b0;
            occupancy      <= 2'd0;
        end else begin
            if (issue) begin
                inflight_valid <= 1'b1;
                inflight_pc    <= fetch_pc;
                fetch_pc       <= fetch_pc + 32'd4;
            end else begin
                inflight_valid <= 1'b0;
            end

            // The head slot is always the oldest entry, so a pop shifts the tail forward.
            case ({push, pop})
                2'b10: begin
                    if (occupancy == 2'd0) begin
                        head_pc    <= inflight_pc;
                        head_instr <= imem_data;
                    end else begin
                        tail_pc    <= inflight_pc;
                        tail_instr <= imem_data;
                    end
                    occupancy <= occupancy + 2'd1;
                end
                2'b01: begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    occupancy  <= occupancy - 2'd1;
                end
                2'b11: begin
                    if (occupancy == 2'd1) begin
                        head_pc    <= inflight_pc;
                        head_instr <= imem_data;
                    end else begin
                        head_pc    <= tail_pc;
                        head_instr <= tail_instr;
                        tail_pc    <= inflight_pc;
                        tail_instr <= imem_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by random traffic,
// checked against a stream-level model (expected next pc, issue counts, arrival delay).
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int total;
    int bad;

    // Model state: words fetched and waiting in the queue, one word in flight,
    // the next address fetch should present and the next pc decode should see.
    int          model_avail;
    int          model_inflight;
    logic [31:0] model_fetch;
    logic [31:0] model_next_pc;
    logic        model_after_reset;

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        case (addr)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            default: return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Synchronous-read instruction memory: data follows the address by one cycle.
    always @(posedge clock) imem_data <= memWord(imem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h want %h", tag, $time, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic exp_valid;
        logic exp_pop;
        logic exp_issue;
        @(negedge clock);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        if (model_after_reset) begin
            checkOutput("reset_out_pc", out_pc, 32'h0);
            checkOutput("reset_out_instr", out_instr, 32'h0);
        end
        exp_valid = (model_avail != 0);
        exp_pop   = exp_valid && rdy;
        exp_issue = !r && !rv && ((model_avail + model_inflight - int'(exp_pop)) < 2);
        checkOutput("out_valid", {31'h0, out_valid}, {31'h0, exp_valid});
        checkOutput("imem_addr", imem_addr, model_fetch);
        checkOutput("imem_req", {31'h0, imem_req}, {31'h0, exp_issue});
        if (exp_valid) begin
            checkOutput("out_pc", out_pc, model_next_pc);
            checkOutput("out_instr", out_instr, memWord(model_next_pc));
        end
        if (exp_pop) model_next_pc = model_next_pc + 32'd4;
        if (r) begin
            model_avail       = 0;
            model_inflight    = 0;
            model_fetch       = RESET_PC;
            model_next_pc     = RESET_PC;
            model_after_reset = 1'b1;
        end else if (rv) begin
            model_avail       = 0;
            model_inflight    = 0;
            model_fetch       = {rpc[31:2], 2'b00};
            model_next_pc     = {rpc[31:2], 2'b00};
            model_after_reset = 1'b0;
        end else begin
            model_avail       = model_avail - int'(exp_pop) + model_inflight;
            model_inflight    = int'(exp_issue);
            if (exp_issue) model_fetch = model_fetch + 32'd4;
            model_after_reset = 1'b0;
        end
    endtask

    task automatic runReady(input int cycles, input logic rdy);
        for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        reset             = 1'b1;
        redirect_valid    = 1'b0;
        redirect_pc       = 32'h0;
        out_ready         = 1'b1;
        model_avail       = 0;
        model_inflight    = 0;
        model_fetch       = RESET_PC;
        model_next_pc     = RESET_PC;
        model_after_reset = 1'b1;

        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        // Straight-line streaming from reset.
        runReady(6, 1'b1);

        // Decode stalls right after the first word arrives, then drains.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        runReady(2, 1'b1);
        runReady(5, 1'b0);
        runReady(6, 1'b1);

        // Redirect to an unaligned target while the queue is full.
        runReady(4, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0042, 1'b0);
        runReady(6, 1'b1);

        // Redirect coinciding with a pop, then two back-to-back redirects.
        runReady(3, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        runReady(6, 1'b1);

        // Fetch address wraps past the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        runReady(6, 1'b1);

        // Reset mid-stream with a word in flight, overriding a redirect.
        runReady(3, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0500, 1'b1);
        runReady(6, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        rv;
            logic [31:0] rpc;
            logic        rdy;
            r   = ($urandom_range(0, 63) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 32'hFFFF));
            rdy = ($urandom_range(0, 9) < 7);
            applyStimulus(r, rv, rpc, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
